remote_ir_transmitter: RTL and testbench
========================================

# remote_ir_transmitter

- Serial transmitter for the 38 kHz remote-control frame that `RemoteController` decodes.
- Accepts a 16-bit custom code and an 8-bit key code, assembles the 32-bit frame {address, key, ~key}, and shifts it out MSB first on an idle-high line.
- Used as the stimulus source and loopback partner for `RemoteController`, and as the transmit path of the remote-emulation board.
- Runs on the same 304 kHz system clock, so each bit lasts 8 clocks.

## Interface

Parameters:
- CLKS_PER_BIT, 8: clocks per serial bit (304 kHz / 38 kHz); legal values ≥ 2.
- LEAD_BITS, 2: bit-times of forced idle-high before the first data bit; legal values ≥ 1.
- GAP_BITS, 2: bit-times of forced idle-high after the last data bit; legal values ≥ 1.

Ports:
- Clock  in  1  system clock, 304 kHz, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Endereco  in  16  custom code; sampled only when a send is accepted.
- Tecla  in  8  key code; sampled only when a send is accepted.
- Corromper  in  1  error injection; sampled only when a send is accepted.
  - 0: the inverse field is ~Tecla.
  - 1: the inverse field is 8'h00.
- Enviar  in  1  send request; level-sensitive; honoured only in IDLE.
- Serial  out  1  registered IR data line; idle high.
- Busy  out  1  high from acceptance until the frame and gap finish.
- Done  out  1  one-cycle pulse when a frame completes.

## Operation

- Reset (Reset=0): the following take effect immediately and asynchronously:
  - Serial=1, Busy=0, Done=0.
  - State goes to IDLE; all counters and the shift register clear.
- FSM states: IDLE → LEAD → DATA → GAP → IDLE.
- IDLE:
  - Serial=1, Busy=0.
  - On a rising edge with Enviar=1, load the shift register with {Endereco, Tecla, Corromper ? 8'h00 : ~Tecla} and enter LEAD.
- LEAD:
  - Serial=1 for LEAD_BITS×CLKS_PER_BIT cycles, then enter DATA.
- DATA:
  - Serial = shift[31].
  - Every CLKS_PER_BIT cycles, shift left by one and increment a 5-bit bit index.
  - After bit index 31 completes, enter GAP.
- GAP:
  - Serial=1 for GAP_BITS×CLKS_PER_BIT cycles.
  - Then enter IDLE, deassert Busy and pulse Done.
- Enviar while Busy=1 is ignored. No queuing; a held Enviar restarts only once the FSM is back in IDLE.
- Input changes on Endereco, Tecla or Corromper after acceptance do not affect the frame in flight.
- Reset asserted mid-frame aborts the frame: the line returns high with no partial-bit completion and Done is not pulsed.
- Arithmetic and counter widths:
  - Bit-cycle counter width is $clog2(CLKS_PER_BIT); it wraps at CLKS_PER_BIT-1.
  - The phase counter is sized for max(LEAD_BITS, GAP_BITS).
  - Counters never overflow silently; terminal counts are compared explicitly.

## Timing

- Let E be the rising edge that accepts Enviar, and C = CLKS_PER_BIT.
- After E: Busy=1 and state=LEAD.
- Data bit i (i = 31 down to 0):
  - Serial carries frame[i] from edge E+(LEAD_BITS+31−i)×C.
  - It holds for exactly C cycles.
- After edge E+(LEAD_BITS+32)×C: Serial=1 (GAP).
- After edge E+(LEAD_BITS+32+GAP_BITS)×C:
  - Busy=0 and Done=1 for that single cycle.
  - The next Enviar is accepted no earlier than the following edge.
- Busy duration at defaults: 36×8 = 288 cycles.
- Frame period with Enviar held high: 289 cycles.
- Serial is a flop output and carries no combinational path from inputs.

## Structure

- Package `remote_ir_pkg` contains:
  - FRAME_BITS=32 and default CLKS_PER_BIT=8.
  - The FSM state typedef (IDLE, LEAD, DATA, GAP).
  - The function `ir_frame(addr, key, corrupt)` returning the 32-bit frame.
- The package is shared with `RemoteController` for frame layout.
- Sub-module `ir_bit_timer` is a parameterised C-cycle counter:
  - Inputs: clear and enable.
  - Output: `tick` at the last cycle of each bit-time.
- The FSM uses `ir_bit_timer` for all three timed states.

## Test plan

- Reset held low with Enviar=1 → Serial=1, Busy=0, Done=0 throughout. On release, the first frame starts one edge later.
- Send Endereco=16'h0000, Tecla=8'h12, Corromper=0:
  - Sample Serial at mid-bit; the 32 bits must read 32'h000012ED.
  - Busy lasts 288 cycles and Done pulses once.
  - Loopback into `RemoteController` must yield Tecla=8'h12.
- Send Tecla=8'h03 with Corromper=1:
  - The frame reads 32'h00000300.
  - `RemoteController` output stays at 8'h12.
- Send 8'h1A, then 8'h01, with Enviar held high:
  - Frames read 32'h00001AE5 and 32'h000001FE.
  - Frame starts are 289 cycles apart.
  - Receiver outputs are 8'h1A, then 8'h01.
- Pulse Enviar with Tecla=8'hFF at DATA bit 20, changing Tecla at the same time → ignored; the current frame finishes with its original data.
- Assert Reset at DATA bit 10 → Serial=1 within the same cycle, Busy=0, no Done. A fresh send afterwards completes correctly.

Source files
------------

// File: rtl/remote_ir_pkg.sv
// Shared frame layout and FSM encoding for the 38 kHz remote-control link.
// The receiver side uses the same package so both ends agree on bit order.
package remote_ir_pkg;

    localparam int FRAME_BITS           = 32;
    localparam int DEFAULT_CLKS_PER_BIT = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LEAD = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } ir_state_t;

    // Frame is {address, key, inverted key}; corrupt forces the inverse field to zero
    // so the receiver's integrity check rejects it.
    function automatic logic [FRAME_BITS-1:0] ir_frame(
        input logic [15:0] addr,
        input logic [7:0]  key,
        input logic        corrupt
    );
        return {addr, key, (corrupt ? 8'h00 : ~key)};
    endfunction

endpackage

// File: rtl/ir_bit_timer.sv
// Free-running bit-time counter. tick marks the last clock of each bit-time
// so the FSM can advance exactly on bit boundaries.
module ir_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int              CW   = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && (cnt == LAST);

    // Count clocks within a bit-time; wrap explicitly at the terminal count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= tick ? '0 : cnt + CW'(1);
        end
    end

endmodule

// File: rtl/remote_ir_transmitter.sv
// Serial IR frame transmitter: lead-in idle, 32 data bits MSB first, trailing gap.
// Line idles high; all outputs are registered.
//
// Handshake: Enviar is a level request sampled only in IDLE. The rising edge that
// sees Enviar=1 in IDLE accepts the frame and latches Endereco/Tecla/Corromper;
// Busy stays high until the gap ends, when Done pulses for one cycle. Requests
// while Busy=1 are dropped, never queued.
module remote_ir_transmitter
    import remote_ir_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int LEAD_BITS    = 2,
    parameter int GAP_BITS     = 2
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [15:0] Endereco,
    input  logic [7:0]  Tecla,
    input  logic        Corromper,
    input  logic        Enviar,
    output logic        Serial,
    output logic        Busy,
    output logic        Done,
    output ir_state_t   dbg_state
);

    localparam int            PHASE_MAX = (LEAD_BITS > GAP_BITS) ? LEAD_BITS : GAP_BITS;
    localparam int            PW        = $clog2(PHASE_MAX + 1);
    localparam logic [PW-1:0] LEAD_LAST = PW'(LEAD_BITS - 1);
    localparam logic [PW-1:0] GAP_LAST  = PW'(GAP_BITS - 1);
    localparam logic [4:0]    BIT_LAST  = 5'(FRAME_BITS - 1);

    ir_state_t             state;
    logic [FRAME_BITS-1:0] shift;
    logic [4:0]            bit_idx;
    logic [PW-1:0]         phase;
    logic                  tick;
    logic                  timer_clear;
    logic                  timer_enable;

    assign timer_clear  = (state == IDLE);
    assign timer_enable = (state != IDLE);
    assign dbg_state    = state;

    ir_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk    (Clock),
        .rst_n  (Reset),
        .clear  (timer_clear),
        .enable (timer_enable),
        .tick   (tick)
    );

    // Frame sequencer: every state change and output update lands on a bit boundary.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state   <= IDLE;
            shift   <= '0;
            bit_idx <= '0;
            phase   <= '0;
            Serial  <= 1'b1;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            Done <= 1'b0;
            case (state)
                IDLE: begin
                    Serial  <= 1'b1;
                    Busy    <= 1'b0;
                    phase   <= '0;
                    bit_idx <= '0;
                    if (Enviar) begin
                        shift <= ir_frame(Endereco, Tecla, Corromper);
                        Busy  <= 1'b1;
                        state <= LEAD;
                    end
                end
                LEAD: begin
                    if (tick) begin
                        if (phase == LEAD_LAST) begin
                            phase  <= '0;
                            Serial <= shift[FRAME_BITS-1];
                            state  <= DATA;
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        shift   <= {shift[FRAME_BITS-2:0], 1'b0};
                        bit_idx <= bit_idx + 5'd1;
                        if (bit_idx == BIT_LAST) begin
                            Serial <= 1'b1;
                            state  <= GAP;
                        end else begin
                            Serial <= shift[FRAME_BITS-2];
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        if (phase == GAP_LAST) begin
                            phase <= '0;
                            Busy  <= 1'b0;
                            Done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            phase <= phase + PW'(1);
                        end
                    end
                end
                default: begin
                    Serial <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_remote_ir_transmitter.sv
// Bench for remote_ir_transmitter: drives frames, captures the line at mid-bit,
// and compares captured frames and timing against expected values queued at send time.
module tb_remote_ir_transmitter;
    import remote_ir_pkg::*;

    localparam int C        = 8;
    localparam int L        = 2;
    localparam int G        = 2;
    localparam int BUSY_LEN = (L + 32 + G) * C;
    localparam int PERIOD   = BUSY_LEN + 1;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [15:0] Endereco = '0;
    logic [7:0]  Tecla = '0;
    logic        Corromper = 1'b0;
    logic        Enviar = 1'b0;
    logic        Serial;
    logic        Busy;
    logic        Done;
    ir_state_t   dbg_state;

    int          total = 0;
    int          bad = 0;
    logic [31:0] exp_q[$];

    int          cyc = 0;
    logic        busy_d = 1'b0;
    int          k = 0;
    logic [31:0] cap = '0;
    int          start_prev = 0;
    logic        expect_abort = 1'b0;
    logic        expect_b2b = 1'b0;
    logic [7:0]  rx_key = 8'h00;
    int          frames_done = 0;

    remote_ir_transmitter #(
        .CLKS_PER_BIT(C),
        .LEAD_BITS   (L),
        .GAP_BITS    (G)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Endereco  (Endereco),
        .Tecla     (Tecla),
        .Corromper (Corromper),
        .Enviar    (Enviar),
        .Serial    (Serial),
        .Busy      (Busy),
        .Done      (Done),
        .dbg_state (dbg_state)
    );

    // Clock / cycle counter.
    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_frame(input logic [15:0] a, input logic [7:0] t,
                                                input logic c);
        logic [7:0] inv;
        inv = c ? 8'h00 : ~t;
        return {a, t, inv};
    endfunction

    // Drive a request and return #1 after the accepting edge; DUT must be idle.
    task automatic send_start(input logic [15:0] a, input logic [7:0] t, input logic c);
        Endereco = a;
        Tecla = t;
        Corromper = c;
        Enviar = 1'b1;
        exp_q.push_back(model_frame(a, t, c));
        @(posedge Clock);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge Clock);
            if (!Busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check(tag, Busy, 1'b0);
        repeat (3) @(negedge Clock);
    endtask

    // Monitor / scoreboard: k counts cycles after the accepting edge.
    always @(negedge Clock) begin
        logic busy_fall;
        logic [31:0] exp;
        busy_fall = busy_d && !Busy;
        if (Busy && !busy_d) begin
            k = 0;
            cap = '0;
            if (expect_b2b) check("period", cyc - start_prev, PERIOD);
            start_prev = cyc;
        end else if (Busy) begin
            k++;
        end
        if (Busy) begin
            if (k == (L * C) / 2) check("lead_idle", Serial, 1'b1);
            if (k >= L * C && k < (L + 32) * C && ((k - L * C) % C) == C / 2)
                cap = {cap[30:0], Serial};
            if (k == (L + 32) * C + C / 2) check("gap_idle", Serial, 1'b1);
        end
        if (busy_fall) begin
            if (expect_abort) begin
                check("abort_no_done", Done, 1'b0);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                expect_abort = 1'b0;
            end else begin
                check("busy_len", k + 1, BUSY_LEN);
                check("done_pulse", Done, 1'b1);
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL frame: got=%h exp=none", cap);
                end else begin
                    exp = exp_q.pop_front();
                    check("frame", cap, exp);
                    if (cap[7:0] == ~cap[15:8]) rx_key = cap[15:8];
                end
                frames_done++;
            end
        end else if (Done) begin
            check("stray_done", Done, 1'b0);
        end
        busy_d = Busy;
    end

    initial begin
        logic [15:0] ra;
        logic [7:0]  rt;

        // Reset held with a pending request: line must stay idle.
        Reset = 1'b0;
        Endereco = 16'h0000;
        Tecla = 8'h12;
        Enviar = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clock);
            check("rst_serial", Serial, 1'b1);
            check("rst_busy", Busy, 1'b0);
            check("rst_done", Done, 1'b0);
        end
        check("rst_state", dbg_state, IDLE);

        // Release: first frame 0000/12 accepted on the next edge.
        exp_q.push_back(model_frame(16'h0000, 8'h12, 1'b0));
        Reset = 1'b1;
        @(posedge Clock);
        #1;
        check("accept_busy", Busy, 1'b1);
        check("accept_state", dbg_state, LEAD);
        Enviar = 1'b0;
        wait_idle("timeout_f1");
        check("rx_key_12", rx_key, 8'h12);

        // Corrupted frame: receiver model must keep the previous key.
        send_start(16'h0000, 8'h03, 1'b1);
        Enviar = 1'b0;
        Corromper = 1'b0;
        wait_idle("timeout_corrupt");
        check("rx_key_kept", rx_key, 8'h12);

        // Back-to-back with Enviar held high.
        send_start(16'h0000, 8'h1A, 1'b0);
        Tecla = 8'h01;
        exp_q.push_back(model_frame(16'h0000, 8'h01, 1'b0));
        repeat (10) @(posedge Clock);
        expect_b2b = 1'b1;
        repeat (PERIOD - 10) @(posedge Clock);
        #1;
        Enviar = 1'b0;
        check("b2b_busy", Busy, 1'b1);
        check("rx_key_1a", rx_key, 8'h1A);
        repeat (10) @(posedge Clock);
        expect_b2b = 1'b0;
        wait_idle("timeout_b2b");
        check("rx_key_01", rx_key, 8'h01);

        // Request at data bit 20 with new Tecla: ignored, frame unchanged.
        send_start(16'hBEEF, 8'h5A, 1'b0);
        Enviar = 1'b0;
        repeat ((L + 11) * C + 2) @(posedge Clock);
        #1;
        Tecla = 8'hFF;
        Enviar = 1'b1;
        @(posedge Clock);
        #1;
        Enviar = 1'b0;
        check("ignore_busy", Busy, 1'b1);
        wait_idle("timeout_ignore");
        repeat (20) @(negedge Clock);
        check("no_restart", Busy, 1'b0);

        // Reset at data bit 10: immediate idle line, no Done.
        send_start(16'hA55A, 8'h3C, 1'b0);
        Enviar = 1'b0;
        repeat ((L + 21) * C + 2) @(posedge Clock);
        #1;
        expect_abort = 1'b1;
        Reset = 1'b0;
        #1;
        check("abort_serial", Serial, 1'b1);
        check("abort_busy", Busy, 1'b0);
        check("abort_state", dbg_state, IDLE);
        repeat (3) @(negedge Clock);
        Reset = 1'b1;
        repeat (5) @(negedge Clock);

        // Fresh random frame after the abort.
        ra = 16'($urandom_range(0, 16'hFFFF));
        rt = 8'($urandom_range(0, 8'hFF));
        send_start(ra, rt, 1'b0);
        Enviar = 1'b0;
        wait_idle("timeout_fresh");
        check("rx_key_fresh", rx_key, rt);

        check("frames_done", frames_done, 6);
        check("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
